regfile_wb_arbiter: RTL and testbench

//  Write-port controller for the 16x16 register file (1 write port, 2 sync read ports).

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with zeroing sweep and pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int NREG           = 16,
    parameter int AW             = 4,
    parameter int DW             = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ALU_VALID,
    input  logic [AW-1:0]   ALU_WA,
    input  logic [DW-1:0]   ALU_WD,
    output logic            ALU_READY,
    input  logic            MEM_VALID,
    input  logic [AW-1:0]   MEM_WA,
    input  logic [DW-1:0]   MEM_WD,
    output logic            MEM_READY,
    input  logic            ISSUE_EN,
    input  logic [AW-1:0]   ISSUE_WA,
    input  logic [AW-1:0]   RD1A,
    input  logic [AW-1:0]   RD2A,
    output logic            HAZARD,
    output logic [NREG-1:0] PENDING,
    output logic            RW,
    output logic [AW-1:0]   WA,
    output logic [DW-1:0]   RWD,
    output logic            INIT_DONE
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   ptr;
    logic            last_mem;
    logic            sweep_last;
    logic            alu_grant;
    logic            mem_grant;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] pend_clr;
    logic [NREG-1:0] pend_set;

    assign sweep_last = (ptr == AW'(NREG - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (sweep_last) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Tie-break favours whichever source did not win last; a lone requester always wins.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = ptr;
            end
            ST_RUN: begin
                alu_grant = ALU_VALID & (~MEM_VALID | last_mem);
                mem_grant = MEM_VALID & (~ALU_VALID | ~last_mem);
                wr_en     = alu_grant | mem_grant;
                wr_addr   = alu_grant ? ALU_WA : MEM_WA;
                wr_data   = alu_grant ? ALU_WD : MEM_WD;
            end
            default: ;
        endcase
    end

    assign ALU_READY = alu_grant;
    assign MEM_READY = mem_grant;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RW        <= 1'b0;
            WA        <= '0;
            RWD       <= '0;
            INIT_DONE <= ~CLEAR_ON_RESET;
            ptr       <= AW'(1);
            last_mem  <= 1'b1;
        end else begin
            RW <= wr_en;
            if (wr_en) begin
                WA  <= wr_addr;
                RWD <= wr_data;
            end
            if (state == ST_INIT) begin
                ptr <= ptr + AW'(1);
                if (sweep_last) INIT_DONE <= 1'b1;
            end
            if (alu_grant) begin
                last_mem <= 1'b0;
            end else if (mem_grant) begin
                last_mem <= 1'b1;
            end
        end
    end

    // A same-cycle issue to the register being written is younger, so its set wins.
    assign pend_clr = RW ? (NREG'(1) << WA) : '0;
    assign pend_set = (state == ST_RUN && ISSUE_EN) ? (NREG'(1) << ISSUE_WA) : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PENDING <= '0;
        end else begin
            PENDING <= (PENDING & ~pend_clr) | pend_set;
        end
    end

    assign HAZARD = PENDING[RD1A] | PENDING[RD2A];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET, ALU_VALID, MEM_VALID, ISSUE_EN;
    logic [3:0]  ALU_WA, MEM_WA, ISSUE_WA, RD1A, RD2A;
    logic [15:0] ALU_WD, MEM_WD;
    logic        ALU_READY, MEM_READY, HAZARD, RW, INIT_DONE;
    logic [15:0] PENDING, RWD;
    logic [3:0]  WA;

    int checks = 0;
    int failures = 0;

    // Reference model state, advanced once per clock from the specified rules
    logic        m_run, m_done, m_rw, m_last_mem;
    logic [3:0]  m_ptr, m_wa;
    logic [15:0] m_rwd, m_pend;
    bit          m_ar, m_mr;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_WA(ALU_WA), .ALU_WD(ALU_WD), .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_WA(MEM_WA), .MEM_WD(MEM_WD), .MEM_READY(MEM_READY),
        .ISSUE_EN(ISSUE_EN), .ISSUE_WA(ISSUE_WA), .RD1A(RD1A), .RD2A(RD2A),
        .HAZARD(HAZARD), .PENDING(PENDING), .RW(RW), .WA(WA), .RWD(RWD), .INIT_DONE(INIT_DONE)
    );

    task automatic model_comb();
        m_ar = 1'b0;
        m_mr = 1'b0;
        if (m_run) begin
            if (ALU_VALID && MEM_VALID) begin
                m_ar = m_last_mem;
                m_mr = !m_last_mem;
            end else begin
                m_ar = ALU_VALID;
                m_mr = MEM_VALID;
            end
        end
    endtask

    task automatic model_clock();
        logic [15:0] np;
        if (RESET) begin
            m_run = 1'b0; m_done = 1'b0; m_rw = 1'b0; m_wa = '0; m_rwd = '0;
            m_pend = '0; m_ptr = 4'd1; m_last_mem = 1'b1;
        end else begin
            np = m_pend;
            if (m_rw) np[m_wa] = 1'b0;
            if (m_run && ISSUE_EN) np[ISSUE_WA] = 1'b1;
            if (!m_run) begin
                m_rw = 1'b1; m_wa = m_ptr; m_rwd = '0;
                if (m_ptr == 4'd15) begin m_run = 1'b1; m_done = 1'b1; end
                m_ptr = m_ptr + 4'd1;
            end else if (m_ar) begin
                m_rw = 1'b1; m_wa = ALU_WA; m_rwd = ALU_WD; m_last_mem = 1'b0;
            end else if (m_mr) begin
                m_rw = 1'b1; m_wa = MEM_WA; m_rwd = MEM_WD; m_last_mem = 1'b1;
            end else begin
                m_rw = 1'b0;
            end
            m_pend = np;
        end
    endtask

    task automatic tick();
        model_comb();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++; if ({RW, WA, RWD} !== 21'd0) begin failures++; $display("FAIL reset_wr got=%b/%h/%h exp=0/0/0", RW, WA, RWD); end
        checks++; if (PENDING !== 16'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0000", PENDING); end
        checks++; if (INIT_DONE !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", INIT_DONE); end
        for (int i = 1; i <= 15; i++) begin
            ALU_VALID = 1'b1; MEM_VALID = 1'b1; ISSUE_EN = 1'b1; ISSUE_WA = 4'(i);
            #1;
            checks++; if ({ALU_READY, MEM_READY} !== 2'b00) begin failures++; $display("FAIL sweep_ready got=%b%b exp=00", ALU_READY, MEM_READY); end
            tick();
            checks++; if (RW !== 1'b1 || WA !== 4'(i) || RWD !== 16'h0) begin failures++; $display("FAIL sweep_write got=%b/%h/%h exp=1/%h/0000", RW, WA, RWD, 4'(i)); end
            checks++; if (PENDING !== 16'h0) begin failures++; $display("FAIL sweep_pending got=%h exp=0000", PENDING); end
            if (i < 15) begin
                checks++; if (INIT_DONE !== 1'b0) begin failures++; $display("FAIL sweep_init_done got=%b exp=0", INIT_DONE); end
            end
        end
        ALU_VALID = 1'b0; MEM_VALID = 1'b0; ISSUE_EN = 1'b0;
        tick();
        checks++; if (INIT_DONE !== 1'b1 || RW !== 1'b0) begin failures++; $display("FAIL sweep_done got=%b/%b exp=1/0", INIT_DONE, RW); end
    endtask

    task automatic test_round_robin();
        bit          exp_alu;
        logic [3:0]  ewa;
        logic [15:0] ewd;
        ALU_VALID = 1'b1; MEM_VALID = 1'b1;
        ALU_WA = 4'd1; ALU_WD = 16'hA001; MEM_WA = 4'd2; MEM_WD = 16'hB002;
        for (int k = 0; k < 4; k++) begin
            exp_alu = (k % 2 == 0);
            ewa = exp_alu ? ALU_WA : MEM_WA;
            ewd = exp_alu ? ALU_WD : MEM_WD;
            #1;
            checks++; if (ALU_READY !== exp_alu || MEM_READY !== !exp_alu) begin failures++; $display("FAIL rr_grant k=%0d got=%b%b exp=%b%b", k, ALU_READY, MEM_READY, exp_alu, !exp_alu); end
            tick();
            checks++; if (RW !== 1'b1 || WA !== ewa || RWD !== ewd) begin failures++; $display("FAIL rr_write k=%0d got=%b/%h/%h exp=1/%h/%h", k, RW, WA, RWD, ewa, ewd); end
            if (exp_alu) begin ALU_WA = ALU_WA + 4'd4; ALU_WD = ALU_WD + 16'd1; end
            else begin MEM_WA = MEM_WA + 4'd4; MEM_WD = MEM_WD + 16'd1; end
        end
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;
        tick();
        checks++; if (RW !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", RW); end
    endtask

    task automatic test_single_mem();
        MEM_VALID = 1'b1; MEM_WA = 4'd5; MEM_WD = 16'hBEEF;
        #1;
        checks++; if (MEM_READY !== 1'b1 || ALU_READY !== 1'b0) begin failures++; $display("FAIL mem_ready got=%b%b exp=01", ALU_READY, MEM_READY); end
        tick();
        MEM_VALID = 1'b0;
        checks++; if (RW !== 1'b1 || WA !== 4'd5 || RWD !== 16'hBEEF) begin failures++; $display("FAIL mem_write got=%b/%h/%h exp=1/5/beef", RW, WA, RWD); end
        tick();
        checks++; if (RW !== 1'b0 || WA !== 4'd5 || RWD !== 16'hBEEF) begin failures++; $display("FAIL mem_hold got=%b/%h/%h exp=0/5/beef", RW, WA, RWD); end
    endtask

    task automatic test_hazard();
        ISSUE_EN = 1'b1; ISSUE_WA = 4'd3;
        tick();
        ISSUE_EN = 1'b0; RD1A = 4'd3; RD2A = 4'd0;
        #1;
        checks++; if (HAZARD !== 1'b1 || PENDING !== 16'h0008) begin failures++; $display("FAIL hazard_rd1 got=%b/%h exp=1/0008", HAZARD, PENDING); end
        RD1A = 4'd0; RD2A = 4'd3;
        #1;
        checks++; if (HAZARD !== 1'b1) begin failures++; $display("FAIL hazard_rd2 got=%b exp=1", HAZARD); end
        ALU_VALID = 1'b1; ALU_WA = 4'd3; ALU_WD = 16'h1234;
        tick();
        ALU_VALID = 1'b0;
        checks++; if (RW !== 1'b1 || WA !== 4'd3 || PENDING !== 16'h0008) begin failures++; $display("FAIL hazard_wr got=%b/%h/%h exp=1/3/0008", RW, WA, PENDING); end
        tick();
        checks++; if (PENDING !== 16'h0000 || HAZARD !== 1'b0) begin failures++; $display("FAIL hazard_clear got=%h/%b exp=0000/0", PENDING, HAZARD); end
        RD2A = 4'd0;
    endtask

    task automatic test_set_wins();
        ISSUE_EN = 1'b1; ISSUE_WA = 4'd7;
        tick();
        ISSUE_EN = 1'b0;
        ALU_VALID = 1'b1; ALU_WA = 4'd7; ALU_WD = 16'h7777;
        tick();
        ALU_VALID = 1'b0; ISSUE_EN = 1'b1; ISSUE_WA = 4'd7;
        checks++; if (RW !== 1'b1 || WA !== 4'd7) begin failures++; $display("FAIL setwin_wr got=%b/%h exp=1/7", RW, WA); end
        tick();
        ISSUE_EN = 1'b0;
        checks++; if (PENDING !== 16'h0080) begin failures++; $display("FAIL setwin_pending got=%h exp=0080", PENDING); end
        tick();
        checks++; if (PENDING !== 16'h0080) begin failures++; $display("FAIL setwin_hold got=%h exp=0080", PENDING); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            if (!(ALU_VALID && !m_ar)) begin
                ALU_VALID = ($urandom % 3) != 0; ALU_WA = 4'($urandom); ALU_WD = 16'($urandom);
            end
            if (!(MEM_VALID && !m_mr)) begin
                MEM_VALID = ($urandom % 3) != 0; MEM_WA = 4'($urandom); MEM_WD = 16'($urandom);
            end
            ISSUE_EN = ($urandom % 3) == 0; ISSUE_WA = 4'($urandom);
            RD1A = 4'($urandom); RD2A = 4'($urandom);
            #1;
            model_comb();
            checks++; if (ALU_READY !== m_ar || MEM_READY !== m_mr) begin failures++; $display("FAIL rand_ready n=%0d got=%b%b exp=%b%b", n, ALU_READY, MEM_READY, m_ar, m_mr); end
            checks++; if (HAZARD !== (m_pend[RD1A] | m_pend[RD2A])) begin failures++; $display("FAIL rand_hazard n=%0d got=%b exp=%b", n, HAZARD, m_pend[RD1A] | m_pend[RD2A]); end
            tick();
            checks++; if (RW !== m_rw || WA !== m_wa || RWD !== m_rwd) begin failures++; $display("FAIL rand_write n=%0d got=%b/%h/%h exp=%b/%h/%h", n, RW, WA, RWD, m_rw, m_wa, m_rwd); end
            checks++; if (PENDING !== m_pend) begin failures++; $display("FAIL rand_pending n=%0d got=%h exp=%h", n, PENDING, m_pend); end
        end
        ALU_VALID = 1'b0; MEM_VALID = 1'b0; ISSUE_EN = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        MEM_VALID = 1'b1; MEM_WA = 4'd9; MEM_WD = 16'hCAFE;
        ISSUE_EN = 1'b1; ISSUE_WA = 4'd2; RESET = 1'b1;
        tick();
        RESET = 1'b0; MEM_VALID = 1'b0; ISSUE_EN = 1'b0;
        checks++; if (RW !== 1'b0 || PENDING !== 16'h0 || INIT_DONE !== 1'b0) begin failures++; $display("FAIL midreset got=%b/%h/%b exp=0/0000/0", RW, PENDING, INIT_DONE); end
        tick();
        checks++; if (RW !== 1'b1 || WA !== 4'd1 || RWD !== 16'h0) begin failures++; $display("FAIL midreset_sweep got=%b/%h/%h exp=1/1/0000", RW, WA, RWD); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (INIT_DONE !== m_done || RW !== m_rw) begin failures++; $display("FAIL midreset_done got=%b/%b exp=%b/%b", INIT_DONE, RW, m_done, m_rw); end
    endtask

    initial begin
        RESET = 1'b0; ALU_VALID = 1'b0; MEM_VALID = 1'b0; ISSUE_EN = 1'b0;
        ALU_WA = '0; MEM_WA = '0; ISSUE_WA = '0; RD1A = '0; RD2A = '0;
        ALU_WD = '0; MEM_WD = '0;
        m_ar = 1'b0; m_mr = 1'b0;
        @(negedge CLK);
        test_reset();
        test_round_robin();
        test_single_mem();
        test_hazard();
        test_set_wins();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
